// File: rtl/bfloat16_accumulator_if.sv
// Term/result bus between the bfloat16 product source and bfloat16_accumulator.
// master = upstream producer / result consumer side, slave = accumulator side.
interface bfloat16_accumulator_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             clear;
    logic [15:0]      sum;
    logic             sum_valid;
    logic [CNT_W-1:0] term_count;

    modport master (
        output in_valid, in_data, clear,
        input  in_ready, sum, sum_valid, term_count
    );

    modport slave (
        input  in_valid, in_data, clear,
        output in_ready, sum, sum_valid, term_count
    );
endinterface

// File: rtl/bfloat16_accumulator.sv
// Sums LEN bfloat16 terms through an IDLE/ALIGN/ADD/NORM loop, one term per 4 cycles.
// Define BF16_ACC_SAT_EN to saturate exponent overflow instead of producing infinity.
module bfloat16_accumulator #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     nreset,
    bfloat16_accumulator_if.slave    bus
);
`ifdef BF16_ACC_SAT_EN
    localparam logic [14:0] OVF_MAG = 15'h7F7F;
`else
    localparam logic [14:0] OVF_MAG = 15'h7F80;
`endif

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t           state;
    logic [15:0]      acc, term, sum_q;
    logic [CNT_W-1:0] count;
    logic             sum_valid_q;

    // Pipeline registers between the phases of one term.
    logic             spec_q, big_sign_q, small_sign_q, res_sign_q;
    logic [15:0]      spec_val_q;
    logic [7:0]       big_exp_q;
    logic [10:0]      big_man_q, small_man_q;
    logic [11:0]      res_man_q;

    logic [7:0]       a_exp, t_exp, diff, big_exp;
    logic [10:0]      a_man, t_man, big_man, small_man, aligned;
    logic             a_special, t_special, a_nan, t_nan, big_sign, small_sign;
    logic             is_special;
    logic [15:0]      special_val;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        a_exp     = acc[14:7];
        t_exp     = term[14:7];
        a_man     = (a_exp == 8'd0) ? 11'd0 : {1'b1, acc[6:0], 3'b000};
        t_man     = (t_exp == 8'd0) ? 11'd0 : {1'b1, term[6:0], 3'b000};
        a_special = (a_exp == 8'hFF);
        t_special = (t_exp == 8'hFF);
        a_nan     = a_special && (acc[6:0] != 7'd0);
        t_nan     = t_special && (term[6:0] != 7'd0);
        if (a_exp >= t_exp) begin
            big_sign = acc[15];  big_exp = a_exp; big_man = a_man;
            small_sign = term[15]; small_man = t_man; diff = a_exp - t_exp;
        end else begin
            big_sign = term[15]; big_exp = t_exp; big_man = t_man;
            small_sign = acc[15]; small_man = a_man; diff = t_exp - a_exp;
        end
        aligned    = (diff >= 8'd11) ? 11'd0 : small_man >> diff;
        is_special = a_special | t_special;
        if (a_nan || t_nan || (a_special && t_special && (acc[15] != term[15])))
            special_val = 16'h7FC0;
        else if (a_special)
            special_val = acc;
        else
            special_val = term;
    end

    logic [11:0] res_man;
    logic        res_sign;

    always_comb begin
        if (big_sign_q == small_sign_q) begin
            res_man  = {1'b0, big_man_q} + {1'b0, small_man_q};
            res_sign = big_sign_q;
        end else if (big_man_q >= small_man_q) begin
            res_man  = {1'b0, big_man_q - small_man_q};
            res_sign = big_sign_q;
        end else begin
            res_man  = {1'b0, small_man_q - big_man_q};
            res_sign = small_sign_q;
        end
    end

    logic [3:0]        lz;
    logic [10:0]       norm_man;
    logic [6:0]        norm_frac;
    logic signed [9:0] norm_exp;
    logic [15:0]       result;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i <= 10; i++)
            if (res_man_q[i]) lz = 4'(10 - i);
        if (res_man_q[11]) begin
            norm_man = res_man_q[11:1];
            norm_exp = $signed({2'b00, big_exp_q}) + 10'sd1;
        end else begin
            norm_man = res_man_q[10:0] << lz;
            norm_exp = $signed({2'b00, big_exp_q}) - $signed({6'd0, lz});
        end
        // Guard bits are simply dropped: round toward zero.
        norm_frac = 7'(norm_man >> 3);
        if (spec_q)
            result = spec_val_q;
        else if (res_man_q == 12'd0)
            result = 16'h0000;
        else if (norm_exp <= 10'sd0)
            result = {res_sign_q, 15'd0};
        else if (norm_exp >= 10'sd255)
            result = {res_sign_q, OVF_MAG};
        else
            result = {res_sign_q, norm_exp[7:0], norm_frac};
    end

    // NOTE: datapath staging registers carry no reset; the FSM never reads them before loading.
    always_ff @(posedge clock) begin
        case (state)
            IDLE:  if (bus.in_valid) term <= bus.in_data;
            ALIGN: begin
                spec_q       <= is_special;
                spec_val_q   <= special_val;
                big_sign_q   <= big_sign;
                big_exp_q    <= big_exp;
                big_man_q    <= big_man;
                small_sign_q <= small_sign;
                small_man_q  <= aligned;
            end
            ADD: begin
                res_man_q  <= res_man;
                res_sign_q <= res_sign;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            acc         <= 16'h0000;
            count       <= '0;
            sum_q       <= 16'h0000;
            sum_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state       <= IDLE;
            acc         <= 16'h0000;
            count       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    count <= count + CNT_W'(1);
                    state <= ALIGN;
                end
                ALIGN: state <= ADD;
                ADD:   state <= NORM;
                NORM: begin
                    if (count == CNT_W'(LEN)) begin
                        sum_q       <= result;
                        sum_valid_q <= 1'b1;
                        acc         <= 16'h0000;
                        count       <= '0;
                    end else begin
                        acc <= result;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.sum        = sum_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.term_count = count;
endmodule

// File: tb/tb_bfloat16_accumulator.sv
// Self-checking bench for bfloat16_accumulator: directed cases plus random groups
// compared against an integer-arithmetic reference model (LEN=4 and LEN=2 instances).
module tb_bfloat16_accumulator;
    localparam int CNT_W = 8;
`ifdef BF16_ACC_SAT_EN
    localparam logic [14:0] OVF = 15'h7F7F;
`else
    localparam logic [14:0] OVF = 15'h7F80;
`endif

    logic        clock = 1'b0;
    logic        nreset;
    logic        sel;        // 0 selects the LEN=4 instance, 1 the LEN=2 instance
    logic        in_valid, clear;
    logic [15:0] in_data;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] terms[$];

    bfloat16_accumulator_if #(.CNT_W(CNT_W)) if4 ();
    bfloat16_accumulator_if #(.CNT_W(CNT_W)) if2 ();

    assign if4.in_valid = in_valid & ~sel;
    assign if4.in_data  = in_data;
    assign if4.clear    = clear & ~sel;
    assign if2.in_valid = in_valid & sel;
    assign if2.in_data  = in_data;
    assign if2.clear    = clear & sel;

    bfloat16_accumulator #(.LEN(4), .CNT_W(CNT_W)) dut4 (.clock(clock), .nreset(nreset), .bus(if4));
    bfloat16_accumulator #(.LEN(2), .CNT_W(CNT_W)) dut2 (.clock(clock), .nreset(nreset), .bus(if2));

    logic             rdy, sv;
    logic [15:0]      sum_o;
    logic [CNT_W-1:0] cnt;
    assign rdy   = sel ? if2.in_ready   : if4.in_ready;
    assign sv    = sel ? if2.sum_valid  : if4.sum_valid;
    assign sum_o = sel ? if2.sum        : if4.sum;
    assign cnt   = sel ? if2.term_count : if4.term_count;

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
    endfunction

    function automatic bit is_inf(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] == 7'd0);
    endfunction

    // Value of a finite operand is man * 2^(exp - 137): 1.fff with three guard bits.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, e, va, vb, s, m;
        bit neg;
        if (is_nan(a) || is_nan(b)) return 16'h7FC0;
        if (is_inf(a) && is_inf(b)) return (a[15] == b[15]) ? a : 16'h7FC0;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        va = (ea == 0) ? 0 : (128 + int'(a[6:0])) * 8;
        vb = (eb == 0) ? 0 : (128 + int'(b[6:0])) * 8;
        e  = (ea > eb) ? ea : eb;
        va = (e - ea >= 11) ? 0 : va >> (e - ea);
        vb = (e - eb >= 11) ? 0 : vb >> (e - eb);
        s  = (a[15] ? -va : va) + (b[15] ? -vb : vb);
        if (s == 0) return 16'h0000;
        neg = (s < 0);
        m   = neg ? -s : s;
        while (m >= 2048) begin m = m / 2; e++; end
        while (m < 1024)  begin m = m * 2; e--; end
        if (e <= 0)   return {neg, 15'd0};
        if (e >= 255) return {neg, OVF};
        return {neg, e[7:0], m[9:3]};
    endfunction

    function automatic logic [15:0] rand_term();
        logic sgn;
        sgn = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 39))
            0:       return 16'h7F80;
            1:       return 16'hFF80;
            2:       return {1'b0, 8'hFF, 7'h05};
            3:       return {sgn, 8'h00, 7'($urandom)};
            4, 5:    return {sgn, 8'hFE, 7'($urandom)};
            6, 7:    return {sgn, 8'($urandom_range(1, 4)), 7'($urandom)};
            8:       return 16'h0000;
            default: return {sgn, 8'($urandom_range(118, 136)), 7'($urandom)};
        endcase
    endfunction

    // Waits (bounded) for in_ready, then presents one term for a single cycle.
    task automatic push(input logic [15:0] d, input int exp_count);
        int n = 0;
        while (rdy !== 1'b1 && n < 16) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", 32'(rdy), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        in_valid = 1'b0;
        check("term_count", 32'(cnt), 32'(exp_count));
        check("ready_busy", 32'(rdy), 32'd0);
    endtask

    // Called right after the group's last accept: sum_valid must appear exactly at T+4.
    task automatic finish_group(input logic [15:0] exp_sum, input string tag);
        repeat (2) begin
            @(negedge clock);
            check({tag, "_early_valid"}, 32'(sv), 32'd0);
        end
        @(negedge clock);
        check({tag, "_valid"}, 32'(sv), 32'd1);
        check({tag, "_sum"}, 32'(sum_o), 32'(exp_sum));
        check({tag, "_count_wrap"}, 32'(cnt), 32'd0);
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        @(negedge clock);
        check({tag, "_valid_pulse"}, 32'(sv), 32'd0);
    endtask

    task automatic run_group(input logic [15:0] exp_sum, input string tag);
        foreach (terms[i]) push(terms[i], i + 1);
        finish_group(exp_sum, tag);
    endtask

    initial begin
        logic [15:0] acc;
        int          len;
        nreset = 1'b1; sel = 1'b0; in_valid = 1'b0; clear = 1'b0; in_data = 16'h0000;

        // Reset asserted between clock edges.
        #2 nreset = 1'b0;
        #2;
        check("rst_sum4", 32'(if4.sum), 32'd0);
        check("rst_valid4", 32'(if4.sum_valid), 32'd0);
        check("rst_count4", 32'(if4.term_count), 32'd0);
        check("rst_ready4", 32'(if4.in_ready), 32'd1);
        check("rst_sum2", 32'(if2.sum), 32'd0);
        check("rst_ready2", 32'(if2.in_ready), 32'd1);
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);

        sel = 1'b0;
        terms = {16'h3F80, 16'h3F80, 16'h4000, 16'h4040};
        run_group(16'h40E0, "dot4");

        sel = 1'b1;
        terms = {16'h4040, 16'hC040};
        run_group(16'h0000, "cancel");
        terms = {16'h4B80, 16'h3F80};
        run_group(16'h4B80, "align_loss");
        terms = {16'h7F00, 16'h7F00};
        run_group({1'b0, OVF}, "overflow");
        terms = {16'h7FC0, 16'h3F80};
        run_group(16'h7FC0, "nan");

        // Abort in ADD after one completed term; accumulator must be discarded.
        push(16'h4000, 1);
        push(16'h3F80, 2);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("abort_ready", 32'(rdy), 32'd1);
        check("abort_count", 32'(cnt), 32'd0);
        check("abort_valid", 32'(sv), 32'd0);
        check("abort_sum_held", 32'(sum_o), 32'h7FC0);

        // clear beats a same-cycle handshake.
        in_valid = 1'b1; in_data = 16'h4040; clear = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; clear = 1'b0;
        check("clear_prio_count", 32'(cnt), 32'd0);
        check("clear_prio_ready", 32'(rdy), 32'd1);

        // Terms offered while busy are ignored.
        push(16'h3F80, 1);
        in_valid = 1'b1; in_data = 16'h4000;
        @(negedge clock);
        check("busy_ignore_a", 32'(cnt), 32'd1);
        @(negedge clock);
        check("busy_ignore_b", 32'(cnt), 32'd1);
        in_valid = 1'b0;
        push(16'h3F80, 2);
        finish_group(16'h4000, "after_clear");

        // Reset in the ADD state, then a fresh group must sum from zero.
        push(16'h4000, 1);
        push(16'h3F80, 2);
        @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy), 32'd1);
        check("midrst_count", 32'(cnt), 32'd0);
        check("midrst_sum", 32'(sum_o), 32'd0);
        check("midrst_valid", 32'(sv), 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        terms = {16'h3F80, 16'h3F80};
        run_group(16'h4000, "after_reset");

        for (int g = 0; g < 42; g++) begin
            sel = (g < 30) ? 1'b1 : 1'b0;
            len = sel ? 2 : 4;
            acc = 16'h0000;
            terms.delete();
            for (int k = 0; k < len; k++) begin
                terms.push_back(rand_term());
                acc = ref_add(acc, terms[k]);
            end
            run_group(acc, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
